// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider sequencing stage.
package div_pkg;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_INIT = 2'b00;
  localparam logic [SEL_W-1:0] SEL_FEED = 2'b01;
  localparam logic [SEL_W-1:0] SEL_RND  = 2'b10;
  localparam logic [SEL_W-1:0] SEL_HOLD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    ROUND,
    DONE
  } div_state_t;

  // Operand-mux select presented while the FSM sits in a given state.
  function automatic logic [SEL_W-1:0] sel_of(input div_state_t s);
    logic [SEL_W-1:0] v;
    v = SEL_HOLD;
    case (s)
      LOAD:    v = SEL_INIT;
      ITER:    v = SEL_FEED;
      ROUND:   v = SEL_RND;
      default: v = SEL_HOLD;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/iter_counter.sv
// Refinement-iteration counter with clear, enable and terminal count.
module iter_counter
  import div_pkg::*;
#(
  parameter int unsigned NITER = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc_c
);

  logic [CNT_W-1:0] r_cnt;

  // Count register; clear wins over enable.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_tc_c = (r_cnt == CNT_W'(NITER - 1));

endmodule

// File: rtl/div_iter_ctrl.sv
// Sequencer for the iterative divider: load, NITER refinements, round, done.
module div_iter_ctrl
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NITER = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] y_in,
  output logic [SEL_W-1:0] sel,
  output logic [CNT_W-1:0] iter_idx,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q
);

  div_state_t       r_state;
  div_state_t       w_state_nxt;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] w_sel_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [WIDTH-1:0] r_q;
  logic             w_capture;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic [CNT_W-1:0] w_cnt;
  logic             w_tc;

  // Counter is held at zero outside ITER so it doubles as iter_idx.
  iter_counter #(
    .NITER (NITER)
  ) u_iter_counter (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .o_cnt  (w_cnt),
    .o_tc_c (w_tc)
  );

  // Next state, counter control, capture enable and next-state output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b1;
    w_cnt_en    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        w_capture   = 1'b1;
        w_state_nxt = ITER;
      end
      ITER: begin
        w_capture = 1'b1;
        if (w_tc) begin
          w_state_nxt = ROUND;
        end else begin
          w_cnt_clr = 1'b0;
          w_cnt_en  = 1'b1;
        end
      end
      ROUND: begin
        w_capture   = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_sel_nxt  = sel_of(w_state_nxt);
    w_busy_nxt = (w_state_nxt == LOAD) || (w_state_nxt == ITER) || (w_state_nxt == ROUND);
    w_done_nxt = (w_state_nxt == DONE);
  end

  // State register with Moore outputs registered alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= SEL_HOLD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Working register captures the mux output on every active step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (w_capture) begin
      r_q <= y_in;
    end
  end

  assign sel      = r_sel;
  assign iter_idx = w_cnt;
  assign busy     = r_busy;
  assign done     = r_done;
  assign q        = r_q;

endmodule
